// File: rtl/filter_coe_ctrl.sv
// Double-buffered coefficient bank for the stream convolution filter; the shadow bank is
// promoted to the active bank only at a start-of-frame handshake. Optional macro: COE_SUM_CHECK_EN.
module filter_coe_ctrl #(
    parameter int FILTER_CORE_DIM = 5,
    parameter int COE_WIDTH       = 16
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   cfg_wr_en,
    input  logic [7:0]                                             cfg_wr_addr,
    input  logic [COE_WIDTH-1:0]                                   cfg_wr_data,
    input  logic                                                   cfg_commit,
    output logic                                                   cfg_busy,
    output logic                                                   cfg_done,
    output logic                                                   cfg_reject,
    output logic                                                   cfg_addr_err,
    input  logic                                                   vid_tvalid,
    input  logic                                                   vid_tready,
    input  logic                                                   vid_tuser,
    output logic [FILTER_CORE_DIM*FILTER_CORE_DIM*COE_WIDTH-1:0]   coe_flat,
    output logic                                                   coe_swap
);
    localparam int NUM_TAPS   = FILTER_CORE_DIM * FILTER_CORE_DIM;
    localparam int CENTER_TAP = NUM_TAPS / 2;
    localparam int IDX_W      = $clog2(NUM_TAPS);
    localparam logic signed [COE_WIDTH-1:0] PASS_VAL   = {1'b0, {(COE_WIDTH-1){1'b1}}};
    localparam logic [8:0]                  NUM_TAPS_W = 9'(NUM_TAPS);

`ifdef COE_SUM_CHECK_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ARMED = 2'd2,
        ST_SWAP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd2,
        ST_SWAP  = 2'd3
    } state_t;
`endif

    state_t state_reg, state_next;

    logic signed [COE_WIDTH-1:0] shadow_reg [NUM_TAPS];
    logic signed [COE_WIDTH-1:0] active_reg [NUM_TAPS];

    logic done_reg;
    logic swap_reg;
    logic addr_err_reg;

    logic wr_accept;
    logic addr_ok;
    logic sof;
    logic enter_armed;

    assign wr_accept   = (state_reg == ST_IDLE) && cfg_wr_en;
    assign addr_ok     = ({1'b0, cfg_wr_addr} < NUM_TAPS_W);
    assign sof         = vid_tvalid & vid_tready & vid_tuser;
    assign enter_armed = (state_next == ST_ARMED) && (state_reg != ST_ARMED);

`ifdef COE_SUM_CHECK_EN
    // DC-gain check: accumulator wide enough that the sum of all taps cannot overflow.
    localparam int ACC_W = COE_WIDTH + IDX_W;
    localparam logic signed [ACC_W-1:0] SUM_MAX  = ACC_W'(2 ** (COE_WIDTH - 1));
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_TAPS - 1);

    logic [IDX_W-1:0]        idx_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [COE_WIDTH-1:0] cur_tap;
    logic last_tap;
    logic sum_ok;
    logic reject_reg;

    assign cur_tap  = shadow_reg[idx_reg];
    assign acc_sum  = acc_reg + ACC_W'(cur_tap);
    assign last_tap = (idx_reg == LAST_IDX);
    assign sum_ok   = !acc_sum[ACC_W-1] && (acc_sum <= SUM_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg    <= '0;
            acc_reg    <= '0;
            reject_reg <= 1'b0;
        end else begin
            reject_reg <= (state_reg == ST_CHECK) && last_tap && !sum_ok;
            if (state_reg == ST_CHECK) begin
                idx_reg <= idx_reg + 1'b1;
                acc_reg <= acc_sum;
            end else begin
                idx_reg <= '0;
                acc_reg <= '0;
            end
        end
    end

    assign cfg_reject = reject_reg;
`else
    assign cfg_reject = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cfg_commit) begin
`ifdef COE_SUM_CHECK_EN
                    state_next = ST_CHECK;
`else
                    state_next = ST_ARMED;
`endif
                end
            end
`ifdef COE_SUM_CHECK_EN
            ST_CHECK: begin
                if (last_tap) begin
                    state_next = sum_ok ? ST_ARMED : ST_IDLE;
                end
            end
`endif
            ST_ARMED: begin
                if (sof) begin
                    state_next = ST_SWAP;
                end
            end
            ST_SWAP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // A write that coincides with the commit lands here first, so it is part of the commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                shadow_reg[i] <= (i == CENTER_TAP) ? PASS_VAL : '0;
                active_reg[i] <= (i == CENTER_TAP) ? PASS_VAL : '0;
            end
        end else begin
            if (wr_accept && addr_ok) begin
                shadow_reg[cfg_wr_addr[IDX_W-1:0]] <= cfg_wr_data;
            end
            if (state_reg == ST_SWAP) begin
                for (int i = 0; i < NUM_TAPS; i++) begin
                    active_reg[i] <= shadow_reg[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            done_reg     <= 1'b0;
            swap_reg     <= 1'b0;
            addr_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == ST_SWAP);
            swap_reg  <= (state_reg == ST_SWAP);
            // An accepted commit wins over a bad write in the same cycle.
            if (enter_armed) begin
                addr_err_reg <= 1'b0;
            end else if (wr_accept && !addr_ok) begin
                addr_err_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TAPS; gi++) begin : g_flat
            assign coe_flat[gi*COE_WIDTH +: COE_WIDTH] = active_reg[gi];
        end
    endgenerate

    assign cfg_busy     = (state_reg != ST_IDLE);
    assign cfg_done     = done_reg;
    assign coe_swap     = swap_reg;
    assign cfg_addr_err = addr_err_reg;

endmodule

// File: tb/tb_filter_coe_ctrl.sv
// Directed bench for filter_coe_ctrl: reset passthrough, commit/SOF swap timing,
// ignored writes and handshakes, address errors and reset while armed.
module tb_filter_coe_ctrl;
    localparam int N  = 5;
    localparam int W  = 16;
    localparam int NT = N * N;
`ifdef COE_SUM_CHECK_EN
    localparam int LAT = NT + 1;
`else
    localparam int LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cfg_wr_en = 1'b0;
    logic [7:0]      cfg_wr_addr = '0;
    logic [W-1:0]    cfg_wr_data = '0;
    logic            cfg_commit = 1'b0;
    logic            cfg_busy, cfg_done, cfg_reject, cfg_addr_err;
    logic            vid_tvalid = 1'b0, vid_tready = 1'b0, vid_tuser = 1'b0;
    logic [NT*W-1:0] coe_flat;
    logic            coe_swap;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_bank [NT];

    filter_coe_ctrl #(.FILTER_CORE_DIM(N), .COE_WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .cfg_reject(cfg_reject), .cfg_addr_err(cfg_addr_err),
        .vid_tvalid(vid_tvalid), .vid_tready(vid_tready), .vid_tuser(vid_tuser),
        .coe_flat(coe_flat), .coe_swap(coe_swap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bank(input string tag);
        for (int k = 0; k < NT; k++) begin
            check($sformatf("%s tap%0d", tag, k), 64'(coe_flat[k*W +: W]), 64'(exp_bank[k]));
        end
    endtask

    task automatic set_pass();
        for (int k = 0; k < NT; k++) exp_bank[k] = (k == NT/2) ? 16'h7FFF : 16'h0000;
    endtask

    task automatic wr(input int addr, input logic [W-1:0] data);
        cfg_wr_en = 1'b1; cfg_wr_addr = 8'(addr); cfg_wr_data = data;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic sof(input logic rdy);
        vid_tvalid = 1'b1; vid_tuser = 1'b1; vid_tready = rdy;
        tick();
        vid_tvalid = 1'b0; vid_tuser = 1'b0; vid_tready = 1'b0;
    endtask

    initial begin
        // Reset and passthrough hold
        tick(); tick();
        reset = 1'b0;
        repeat (10) tick();
        set_pass();
        check_bank("reset");
        check("reset busy", 64'(cfg_busy), 64'd0);
        check("reset done", 64'(cfg_done), 64'd0);
        check("reset reject", 64'(cfg_reject), 64'd0);
        check("reset addr_err", 64'(cfg_addr_err), 64'd0);
        check("reset swap", 64'(coe_swap), 64'd0);
        $display("reset: passthrough bank checked");

        // Out-of-range write flags error, then load 0x051E with the last write in the commit cycle
        wr(25, 16'hAAAA);
        check("addr_err set", 64'(cfg_addr_err), 64'd1);
        for (int k = 0; k < NT - 1; k++) wr(k, 16'h051E);
        check_bank("shadow only");
        cfg_wr_en = 1'b1; cfg_wr_addr = 8'd24; cfg_wr_data = 16'h051E; cfg_commit = 1'b1;
        tick();
        cfg_wr_en = 1'b0; cfg_commit = 1'b0;
        check("busy after commit", 64'(cfg_busy), 64'd1);
        repeat (LAT - 1) tick();
        check("addr_err cleared", 64'(cfg_addr_err), 64'd0);
        $display("commit: 0x051E bank armed");

        // Writes and stalled SOFs while armed change nothing
        wr(3, 16'h1234);
        sof(1'b0);
        sof(1'b0);
        check("tready0 no swap", 64'(coe_swap), 64'd0);
        check("tready0 busy", 64'(cfg_busy), 64'd1);
        sof(1'b1);
        check_bank("T+1 old taps");
        check("T+1 swap", 64'(coe_swap), 64'd0);
        tick();
        for (int k = 0; k < NT; k++) exp_bank[k] = 16'h051E;
        check_bank("T+2 new taps");
        check("T+2 swap", 64'(coe_swap), 64'd1);
        check("T+2 done", 64'(cfg_done), 64'd1);
        check("T+2 busy", 64'(cfg_busy), 64'd0);
        tick();
        check("T+3 swap", 64'(coe_swap), 64'd0);
        check("T+3 done", 64'(cfg_done), 64'd0);
        $display("swap: 0x051E bank active");

        // SOF while idle is ignored
        sof(1'b1);
        tick();
        check("idle sof swap", 64'(coe_swap), 64'd0);
        check("idle sof busy", 64'(cfg_busy), 64'd0);
        check("idle sof tap0", 64'(coe_flat[0 +: W]), 64'h051E);
        $display("idle sof: ignored");

`ifdef COE_SUM_CHECK_EN
        // Sum 25*0x2000 exceeds unity gain: rejected at commit+26
        for (int k = 0; k < NT; k++) wr(k, 16'h2000);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        repeat (NT - 1) tick();
        check("pre reject", 64'(cfg_reject), 64'd0);
        check("pre reject busy", 64'(cfg_busy), 64'd1);
        tick();
        check("reject pulse", 64'(cfg_reject), 64'd1);
        check("reject busy", 64'(cfg_busy), 64'd0);
        check("reject addr_err", 64'(cfg_addr_err), 64'd0);
        tick();
        check("reject end", 64'(cfg_reject), 64'd0);
        check_bank("after reject");
        $display("check: over-gain bank rejected");
`endif

        // Reset three cycles into ARMED discards the commit and both banks
        for (int k = 0; k < NT; k++) wr(k, 16'h0777);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        repeat (LAT - 1) tick();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_pass();
        check_bank("reset armed");
        check("reset armed busy", 64'(cfg_busy), 64'd0);
        sof(1'b1);
        tick();
        check("post reset sof swap", 64'(coe_swap), 64'd0);
        check("post reset sof done", 64'(cfg_done), 64'd0);
        check_bank("post reset sof");
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        repeat (LAT - 1) tick();
        sof(1'b1);
        tick();
        check("shadow reset done", 64'(cfg_done), 64'd1);
        check_bank("shadow reset");
        $display("reset in armed: pending commit discarded");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
